// File: rtl/syscall_halt_ctrl.sv
// Run-control FSM, syscall decoder, cycle/instruction counters and display channels.
// Optional cycle watchdog enabled by defining SYSCALL_WATCHDOG_EN.
module syscall_halt_ctrl #(
   parameter int              DATA_W     = 32,
   parameter int              NUM_DISP   = 4,
   parameter int              CNT_W      = 32,
   parameter longint unsigned MAX_CYCLES = 64'hFFFF_FFFF,
   localparam int             SEL_W      = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sys_valid,
   input  logic [DATA_W-1:0] sys_code,
   input  logic [DATA_W-1:0] sys_arg,
   input  logic              retire,
   input  logic              stop,
   input  logic              step,
   input  logic              show_cnt,
   input  logic [SEL_W-1:0]  disp_sel,
   output logic              run_en,
   output logic [DATA_W-1:0] sys_ret,
   output logic [DATA_W-1:0] disp_out,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instr_cnt,
   output logic [1:0]        state,
`ifdef SYSCALL_WATCHDOG_EN
   output logic              wdog_to,
`endif
   output logic              err
);

   typedef enum logic [1:0] {
      S_RUN    = 2'b00,
      S_PAUSED = 2'b01,
      S_STEP   = 2'b10,
      S_HALTED = 2'b11
   } state_t;

   localparam logic [DATA_W-1:0] CODE_PRINT = DATA_W'(1);
   localparam logic [DATA_W-1:0] CODE_EXIT  = DATA_W'(10);
   localparam logic [DATA_W-1:0] CODE_TIME  = DATA_W'(30);
   localparam logic [DATA_W-1:0] CODE_INSTR = DATA_W'(41);

   if (NUM_DISP < 1 || (NUM_DISP & (NUM_DISP - 1)) != 0) begin : g_bad_num_disp
      $error("syscall_halt_ctrl: NUM_DISP must be a power of 2 and >= 1");
   end
   if (MAX_CYCLES == 0) begin : g_bad_max_cycles
      $error("syscall_halt_ctrl: MAX_CYCLES must be non-zero");
   end

   state_t             state_q, state_d;
   logic               stop_q;
   logic               stop_edge;
   logic               accept;
   logic               halt_req;
   logic               wd_hit;
   logic               cyc_inc;
   logic [SEL_W-1:0]   wr_ptr;
   logic [SEL_W-1:0]   next_ptr;
   logic [SEL_W-1:0]   rd_idx;
   logic [DATA_W-1:0]  disp_mem [NUM_DISP];

   assign stop_edge = stop && !stop_q;
   assign run_en    = (state_q == S_RUN) || (state_q == S_STEP);
   assign accept    = sys_valid && run_en;
   assign state     = state_q;

`ifdef SYSCALL_WATCHDOG_EN
   // The counter saturates at the limit; the same cycle forces HALTED.
   assign wd_hit = run_en && (cycle_cnt == CNT_W'(MAX_CYCLES));
`else
   assign wd_hit = 1'b0;
`endif

   assign halt_req = (accept && (sys_code == CODE_EXIT)) || wd_hit;
   assign cyc_inc  = run_en && !wd_hit;
   assign next_ptr = (NUM_DISP == 1) ? '0 : wr_ptr + 1'b1;
   assign rd_idx   = (NUM_DISP == 1) ? '0 : disp_sel;
   assign disp_out = show_cnt ? DATA_W'(cycle_cnt) : disp_mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (halt_req)       state_d = S_HALTED;
            else if (stop_edge) state_d = S_PAUSED;
         end
         S_PAUSED: begin
            if (stop_edge)      state_d = S_RUN;
            else if (step)      state_d = S_STEP;
         end
         S_STEP:   state_d = halt_req ? S_HALTED : S_PAUSED;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_q    <= 1'b0;
         cycle_cnt <= '0;
         instr_cnt <= '0;
         sys_ret   <= '0;
         err       <= 1'b0;
         wr_ptr    <= '0;
         // NOTE: the display channels must read 0 after reset, so this small array is reset in full.
         for (int i = 0; i < NUM_DISP; i++) disp_mem[i] <= '0;
      end else begin
         stop_q <= stop;
         if (cyc_inc)           cycle_cnt <= cycle_cnt + 1'b1;
         if (run_en && retire)  instr_cnt <= instr_cnt + 1'b1;
         if (accept) begin
            case (sys_code)
               CODE_PRINT: begin
                  disp_mem[wr_ptr] <= sys_arg;
                  wr_ptr           <= next_ptr;
               end
               CODE_EXIT:  ;
               CODE_TIME:  sys_ret <= DATA_W'(cycle_cnt);
               CODE_INSTR: sys_ret <= DATA_W'(instr_cnt);
               default:    err     <= 1'b1;
            endcase
         end
      end
   end

`ifdef SYSCALL_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      wdog_to <= 1'b0;
      else if (wd_hit) wdog_to <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_syscall_halt_ctrl.sv
// Vector-table bench for syscall_halt_ctrl: expectations are queued at drive time and checked after the edge.
module tb_syscall_halt_ctrl;

   localparam int DATA_W   = 32;
   localparam int NUM_DISP = 4;
   localparam int CNT_W    = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sys_valid = 1'b0;
   logic [DATA_W-1:0] sys_code = '0;
   logic [DATA_W-1:0] sys_arg = '0;
   logic              retire = 1'b0;
   logic              stop = 1'b0;
   logic              step = 1'b0;
   logic              show_cnt = 1'b0;
   logic [1:0]        disp_sel = '0;
   logic              run_en;
   logic [DATA_W-1:0] sys_ret;
   logic [DATA_W-1:0] disp_out;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  instr_cnt;
   logic [1:0]        state;
   logic              err;
`ifdef SYSCALL_WATCHDOG_EN
   logic              wdog_to;
`endif

   int total = 0;
   int bad   = 0;

   syscall_halt_ctrl #(.DATA_W(DATA_W), .NUM_DISP(NUM_DISP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .sys_valid(sys_valid), .sys_code(sys_code),
      .sys_arg(sys_arg), .retire(retire), .stop(stop), .step(step),
      .show_cnt(show_cnt), .disp_sel(disp_sel), .run_en(run_en),
      .sys_ret(sys_ret), .disp_out(disp_out), .cycle_cnt(cycle_cnt),
      .instr_cnt(instr_cnt), .state(state),
`ifdef SYSCALL_WATCHDOG_EN
      .wdog_to(wdog_to),
`endif
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      int         code;
      int         arg;
      logic       ret_i;
      logic       stop_i;
      logic       step_i;
      logic       show;
      logic [1:0] sel;
      logic [1:0] st;
      int         cyc;
      int         ins;
      int         ret;
      logic       er;
      int         disp;
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[15];

   function automatic vec_t mk(input logic v, input int code, input int arg, input logic r,
                               input logic sp, input logic stp, input logic sh, input logic [1:0] sel,
                               input logic [1:0] st, input int cyc, input int ins, input int ret,
                               input logic er, input int disp);
      vec_t x;
      x.valid = v;   x.code = code; x.arg = arg;   x.ret_i = r;
      x.stop_i = sp; x.step_i = stp; x.show = sh;  x.sel = sel;
      x.st = st;     x.cyc = cyc;   x.ins = ins;   x.ret = ret;
      x.er = er;     x.disp = disp;
      return x;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic compare(input vec_t e, input string tag);
      check({tag, ".state"},  64'(state),     64'(e.st));
      check({tag, ".run_en"}, 64'(run_en),    64'((e.st == 2'b00) || (e.st == 2'b10)));
      check({tag, ".cycle"},  64'(cycle_cnt), 64'(unsigned'(e.cyc)));
      check({tag, ".instr"},  64'(instr_cnt), 64'(unsigned'(e.ins)));
      check({tag, ".sysret"}, 64'(sys_ret),   64'(unsigned'(e.ret)));
      check({tag, ".err"},    64'(err),       64'(e.er));
      check({tag, ".disp"},   64'(disp_out),  64'(unsigned'(e.disp)));
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      sys_valid = v.valid;
      sys_code  = DATA_W'(unsigned'(v.code));
      sys_arg   = DATA_W'(unsigned'(v.arg));
      retire    = v.ret_i;
      stop      = v.stop_i;
      step      = v.step_i;
      show_cnt  = v.show;
      disp_sel  = v.sel;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      compare(e, tag);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      sys_valid = 1'b0; sys_code = '0; sys_arg = '0; retire = 1'b0;
      stop = 1'b0; step = 1'b0; show_cnt = 1'b0; disp_sel = '0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".state"},  64'(state),     64'd0);
      check({tag, ".run_en"}, 64'(run_en),    64'd1);
      check({tag, ".cycle"},  64'(cycle_cnt), 64'd0);
      check({tag, ".instr"},  64'(instr_cnt), 64'd0);
      check({tag, ".sysret"}, 64'(sys_ret),   64'd0);
      check({tag, ".err"},    64'(err),       64'd0);
      for (int s = 0; s < NUM_DISP; s++) begin
         disp_sel = 2'(s);
         #1;
         check($sformatf("%s.disp%0d", tag, s), 64'(disp_out), 64'd0);
      end
      disp_sel = '0;
   endtask

   // Asserts reset at a negedge (checked before any clock edge), releases at the next negedge.
   task automatic do_reset(input string tag);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check_reset(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Boot, counting, print wrap-around and queries.
      tbl[0]  = mk(0, 0, 0,     1, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0,     1, 0, 0, 0, 0, 2'b00, 2, 2, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0,     1, 0, 0, 0, 0, 2'b00, 3, 3, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0,     1, 0, 0, 0, 0, 2'b00, 4, 4, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0,     1, 0, 0, 1, 0, 2'b00, 5, 5, 0, 0, 5);
      tbl[5]  = mk(1, 1, 'h11,  1, 0, 0, 0, 0, 2'b00, 6, 6, 0, 0, 'h11);
      tbl[6]  = mk(1, 1, 'h22,  1, 0, 0, 0, 1, 2'b00, 7, 7, 0, 0, 'h22);
      tbl[7]  = mk(1, 1, 'h33,  1, 0, 0, 0, 2, 2'b00, 8, 8, 0, 0, 'h33);
      tbl[8]  = mk(1, 1, 'h44,  1, 0, 0, 0, 3, 2'b00, 9, 9, 0, 0, 'h44);
      tbl[9]  = mk(1, 1, 'h55,  1, 0, 0, 0, 0, 2'b00, 10, 10, 0, 0, 'h55);
      tbl[10] = mk(0, 0, 0,     0, 0, 0, 0, 1, 2'b00, 11, 10, 0, 0, 'h22);
      tbl[11] = mk(1, 30, 0,    0, 0, 0, 0, 2, 2'b00, 12, 10, 11, 0, 'h33);
      tbl[12] = mk(1, 41, 0,    1, 0, 0, 0, 3, 2'b00, 13, 11, 10, 0, 'h44);
      tbl[13] = mk(1, 99, 0,    0, 0, 0, 0, 0, 2'b00, 14, 11, 10, 1, 'h55);
      tbl[14] = mk(0, 0, 0,     0, 0, 0, 1, 0, 2'b00, 15, 11, 10, 1, 15);

      @(negedge clk);
      #1;
      check_reset("boot_reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // Pause, syscall ignored while paused, two single steps, stop-edge-beats-step, resume.
      apply(mk(0, 0, 0,    1, 1, 0, 0, 0, 2'b01, 16, 12, 10, 1, 'h55), "pause");
      apply(mk(1, 1, 'h77, 1, 1, 0, 0, 0, 2'b01, 16, 12, 10, 1, 'h55), "paused_sys");
      apply(mk(0, 0, 0,    0, 1, 1, 0, 0, 2'b10, 16, 12, 10, 1, 'h55), "step1_in");
      apply(mk(0, 0, 0,    1, 1, 0, 0, 0, 2'b01, 17, 13, 10, 1, 'h55), "step1_out");
      apply(mk(0, 0, 0,    0, 0, 1, 0, 0, 2'b10, 17, 13, 10, 1, 'h55), "step2_in");
      apply(mk(0, 0, 0,    1, 0, 0, 0, 0, 2'b01, 18, 14, 10, 1, 'h55), "step2_out");
      apply(mk(0, 0, 0,    0, 0, 0, 0, 0, 2'b01, 18, 14, 10, 1, 'h55), "paused_idle");
      apply(mk(0, 0, 0,    0, 1, 1, 0, 0, 2'b00, 18, 14, 10, 1, 'h55), "resume_wins");
      apply(mk(0, 0, 0,    0, 1, 0, 0, 0, 2'b00, 19, 14, 10, 1, 'h55), "run_again");

      // Exit, then everything is ignored while halted.
      apply(mk(1, 10, 0,   1, 0, 0, 0, 1, 2'b11, 20, 15, 10, 1, 'h22), "exit");
      apply(mk(1, 1, 'h99, 1, 1, 1, 0, 1, 2'b11, 20, 15, 10, 1, 'h22), "halt_print");
      apply(mk(0, 0, 0,    1, 0, 1, 1, 0, 2'b11, 20, 15, 10, 1, 20),   "halt_step");
      apply(mk(1, 30, 0,   0, 1, 0, 0, 1, 2'b11, 20, 15, 10, 1, 'h22), "halt_query");

      // Reset out of HALTED, exit at cycle_cnt=7 freezes the counter at 8.
      do_reset("halt_reset");
      for (int k = 1; k <= 7; k++)
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, k, 0, 0, 0, 0), $sformatf("run%0d", k));
      apply(mk(1, 10, 0, 1, 0, 0, 0, 0, 2'b11, 8, 1, 0, 0, 0), "exit_at7");
      apply(mk(0, 0, 0,  1, 1, 1, 1, 0, 2'b11, 8, 1, 0, 0, 8), "frozen");

      // Exit syscall taken during a single-step cycle.
      do_reset("step_reset");
      apply(mk(0, 0, 0,  0, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0), "se_pause");
      apply(mk(0, 0, 0,  0, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0), "se_step");
      apply(mk(1, 10, 0, 1, 1, 0, 0, 0, 2'b11, 2, 1, 0, 0, 0), "se_exit");
      apply(mk(0, 0, 0,  0, 0, 1, 0, 0, 2'b11, 2, 1, 0, 0, 0), "se_halted");

      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
